// File: rtl/uart_tx_if.sv
// uart_tx_if
//   Bundles the parallel-side handshake and serial outputs of the UART transmitter.
//   master : the block that requests frames (drives i_tx_start / i_data, watches status)
//   slave  : the transmitter itself
//   i_tx_start  request, sampled only while the transmitter is idle
//   i_data      word to send, captured on the accepting clk
//   o_tx        serial line, idles high
//   o_txdone    1-clk pulse at the end of the stop period
//   o_busy      high while a frame is in progress
interface uart_tx_if #(
    parameter int NB_DATA = 8
);
    logic               i_tx_start;
    logic [NB_DATA-1:0] i_data;
    logic               o_tx;
    logic               o_txdone;
    logic               o_busy;

    modport master (
        output i_tx_start,
        output i_data,
        input  o_tx,
        input  o_txdone,
        input  o_busy
    );

    modport slave (
        input  i_tx_start,
        input  i_data,
        output o_tx,
        output o_txdone,
        output o_busy
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx
//   UART serializer driven by the shared 16x baud tick. Latches a word on request and
//   shifts out one frame LSB first: start (0), NB_DATA data bits, stop (1) lasting
//   NB_STOP ticks. All outputs are registered and change on the same edge as the state.
// Ports
//   clk     system clock, rising edge
//   i_rst   synchronous reset, active-high
//   i_tick  1-clk baud strobe (OVERSAMPLE strobes per start/data bit)
//   bus     uart_tx_if.slave: i_tx_start, i_data in; o_tx, o_txdone, o_busy out
//
// state | meaning
// IDLE  | line high, waiting for i_tx_start
// START | line low for OVERSAMPLE ticks
// DATA  | line = shreg[0], one bit per OVERSAMPLE ticks, NB_DATA bits
// STOP  | line high for NB_STOP ticks, then pulse o_txdone
module uart_tx #(
    parameter int NB_DATA    = 8,
    parameter int NB_STOP    = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      i_rst,
    input  logic      i_tick,
    uart_tx_if.slave  bus
);

    localparam int S_MAX = (OVERSAMPLE > NB_STOP) ? OVERSAMPLE : NB_STOP;
    localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int NW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(NB_STOP - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state;
    logic [SW-1:0]      s_cnt;
    logic [NW-1:0]      n_cnt;
    logic [NB_DATA-1:0] shreg;
    logic [NB_DATA-1:0] shreg_nx;
    logic               tx_q;
    logic               done_q;
    logic               busy_q;

    // Next data bit is presented on the same edge that shifts, so the line
    // follows the state without an extra clk of lag.
    always_comb begin
        shreg_nx = shreg >> 1;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state  <= IDLE;
            s_cnt  <= '0;
            n_cnt  <= '0;
            shreg  <= '0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    // A tick on the accept clk is deliberately not counted.
                    if (bus.i_tx_start) begin
                        shreg  <= bus.i_data;
                        s_cnt  <= '0;
                        state  <= START;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (s_cnt == S_BIT_LAST) begin
                            s_cnt <= '0;
                            n_cnt <= '0;
                            state <= DATA;
                            tx_q  <= shreg[0];
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (s_cnt == S_BIT_LAST) begin
                            s_cnt <= '0;
                            shreg <= shreg_nx;
                            if (n_cnt == N_LAST) begin
                                state <= STOP;
                                tx_q  <= 1'b1;
                            end else begin
                                n_cnt <= n_cnt + NW'(1);
                                tx_q  <= shreg_nx[0];
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (s_cnt == S_STOP_LAST) begin
                            state  <= IDLE;
                            tx_q   <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_tx     = tx_q;
    assign bus.o_txdone = done_q;
    assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
//   Directed bench for uart_tx: an 8-bit instance with default framing and a 7-bit
//   instance with a 2-stop-bit period. Expected words go into a queue when a frame is
//   requested; the frame monitor pops them and checks the line tick by tick.
module tb_uart_tx;

    logic clk;
    logic i_rst;
    logic tick;
    int   tick_per;
    int   tick_cnt;
    int   sel;

    int n_cmp;
    int n_fail;

    logic [7:0] exp_q[$];

    logic mon_tx, mon_done, mon_busy;

    uart_tx_if #(.NB_DATA(8)) bus8 ();
    uart_tx_if #(.NB_DATA(7)) bus7 ();

    uart_tx #(.NB_DATA(8), .NB_STOP(16), .OVERSAMPLE(16)) u_dut (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_tick (tick),
        .bus    (bus8.slave)
    );

    uart_tx #(.NB_DATA(7), .NB_STOP(32), .OVERSAMPLE(16)) u_dut7 (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_tick (tick),
        .bus    (bus7.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mon_tx   = bus8.o_tx;
        mon_done = bus8.o_txdone;
        mon_busy = bus8.o_busy;
        if (sel == 1) begin
            mon_tx   = bus7.o_tx;
            mon_done = bus7.o_txdone;
            mon_busy = bus7.o_busy;
        end
    end

    // Tick strobe: one clk in every tick_per clks, changed away from the active edge.
    initial begin
        int ph;
        ph   = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            ph   = (ph + 1 >= tick_per) ? 0 : ph + 1;
            tick = (ph == 0);
        end
    end

    always @(posedge clk) begin
        if (tick) tick_cnt <= tick_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send8(input logic [7:0] d);
        bus8.i_data     = d;
        bus8.i_tx_start = 1'b1;
        exp_q.push_back(d);
        @(negedge clk);
        bus8.i_tx_start = 1'b0;
    endtask

    task automatic send7(input logic [6:0] d);
        bus7.i_data     = d;
        bus7.i_tx_start = 1'b1;
        exp_q.push_back({1'b0, d});
        @(negedge clk);
        bus7.i_tx_start = 1'b0;
    endtask

    // Follows one frame on the selected instance. k0 is the first negedge with the
    // line low; t is the number of ticks seen at edges after the accept edge.
    task automatic recv_frame(input string tag, input int nb, input int os, input int stop_t);
        int         flen;
        int         t, t0, guard, idx;
        int         line_err, busy_err, done_err;
        logic [7:0] exp_w, got_w;
        logic       e;
        flen  = os * (1 + nb) + stop_t;
        guard = 0;
        while (mon_tx !== 1'b0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_start"}, mon_tx, 1'b0);
        if (mon_tx !== 1'b0) return;
        chk({tag, "_sb_has_entry"}, (exp_q.size() > 0), 1'b1);
        exp_w    = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        got_w    = 8'h00;
        line_err = 0;
        busy_err = 0;
        done_err = 0;
        t0       = tick_cnt;
        t        = 0;
        guard    = 0;
        while (t < flen && guard < flen * 8) begin
            if (t < os) begin
                e = 1'b0;
            end else if (t < os * (1 + nb)) begin
                idx        = t / os - 1;
                e          = exp_w[idx];
                got_w[idx] = mon_tx;
            end else begin
                e = 1'b1;
            end
            if (mon_tx !== e)       line_err++;
            if (mon_busy !== 1'b1)  busy_err++;
            if (mon_done !== 1'b0)  done_err++;
            @(negedge clk);
            t = tick_cnt - t0;
            guard++;
        end
        chk({tag, "_length_ticks"}, t, flen);
        chk({tag, "_line_errs"}, line_err, 0);
        chk({tag, "_busy_errs"}, busy_err, 0);
        chk({tag, "_early_done"}, done_err, 0);
        chk({tag, "_txdone"}, mon_done, 1'b1);
        chk({tag, "_busy_end"}, mon_busy, 1'b0);
        chk({tag, "_tx_end"}, mon_tx, 1'b1);
        chk({tag, "_data"}, got_w, exp_w);
    endtask

    initial begin
        int lows, dones, busys;
        n_cmp    = 0;
        n_fail   = 0;
        tick_per = 1;
        tick_cnt = 0;
        sel      = 0;
        bus8.i_tx_start = 1'b0;
        bus8.i_data     = 8'h00;
        bus7.i_tx_start = 1'b0;
        bus7.i_data     = 7'h00;
        i_rst           = 1'b1;

        // Reset held for 3 clks while the request toggles.
        for (int i = 0; i < 3; i++) begin
            bus8.i_tx_start = ~bus8.i_tx_start;
            bus8.i_data     = 8'hFF;
            @(negedge clk);
            chk("rst_tx", bus8.o_tx, 1'b1);
            chk("rst_busy", bus8.o_busy, 1'b0);
            chk("rst_done", bus8.o_txdone, 1'b0);
        end
        bus8.i_tx_start = 1'b0;
        i_rst           = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_tx", bus8.o_tx, 1'b1);
        chk("idle7_tx", bus7.o_tx, 1'b1);

        // Single frame, tick every clk.
        send8(8'hA5);
        recv_frame("a5", 8, 16, 16);
        repeat (5) @(negedge clk);

        // Request held high: back-to-back frames with a single idle clk between.
        bus8.i_data     = 8'h5A;
        bus8.i_tx_start = 1'b1;
        exp_q.push_back(8'h5A);
        @(negedge clk);
        bus8.i_data = 8'hA5;
        exp_q.push_back(8'hA5);
        recv_frame("b2b1", 8, 16, 16);
        @(negedge clk);
        chk("b2b_gap_one_clk", mon_tx, 1'b0);
        bus8.i_tx_start = 1'b0;
        recv_frame("b2b2", 8, 16, 16);
        repeat (5) @(negedge clk);

        // Request mid-DATA is ignored and not queued.
        send8(8'h3C);
        fork
            recv_frame("ign", 8, 16, 16);
            begin
                repeat (60) @(negedge clk);
                bus8.i_data     = 8'hFF;
                bus8.i_tx_start = 1'b1;
                @(negedge clk);
                bus8.i_tx_start = 1'b0;
            end
        join
        lows  = 0;
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mon_tx !== 1'b1)   lows++;
            if (mon_done !== 1'b0) dones++;
        end
        chk("ign_no_second_frame", lows, 0);
        chk("ign_no_second_done", dones, 0);
        chk("ign_sb_empty", exp_q.size(), 0);

        // Reset during data bit 4 of 8'h81, then a clean resend.
        send8(8'h81);
        repeat (85) @(negedge clk);
        chk("abort_bit4_level", mon_tx, 1'b0);
        chk("abort_busy_before", mon_busy, 1'b1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("abort_tx", mon_tx, 1'b1);
        chk("abort_busy", mon_busy, 1'b0);
        chk("abort_done", mon_done, 1'b0);
        void'(exp_q.pop_front());
        lows  = 0;
        dones = 0;
        busys = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mon_tx !== 1'b1)   lows++;
            if (mon_done !== 1'b0) dones++;
            if (mon_busy !== 1'b0) busys++;
        end
        chk("abort_line_idle", lows, 0);
        chk("abort_no_done", dones, 0);
        chk("abort_no_busy", busys, 0);
        send8(8'h81);
        recv_frame("resend", 8, 16, 16);
        repeat (5) @(negedge clk);

        // Sparse ticks: counters must advance only on tick clks.
        tick_per = 3;
        repeat (4) @(negedge clk);
        send8(8'hC3);
        recv_frame("sparse", 8, 16, 16);
        tick_per = 1;
        repeat (5) @(negedge clk);

        // 7 data bits, 32-tick stop.
        sel = 1;
        @(negedge clk);
        send7(7'h55);
        recv_frame("nb7", 7, 16, 32);
        repeat (3) @(negedge clk);
        chk("nb7_idle_after", mon_done, 1'b0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
